instr_prefetch_queue: RTL and testbench

Parametrised instruction fetch front end for the 32-bit pipeline, sitting between the instruction memory and the decoder. It replaces the single-word fetch path with an address generator, a 16/32-bit instruction assembler and a DEPTH-entry prefetch FIFO. Instructions are delivered to the decoder over a valid/ready handshake. Jumps from execute enter through a redirect port that flushes all buffered state.

---
 rtl/instr_prefetch_queue.sv | 135 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front end: address generator, 16/32-bit assembler and DEPTH-entry prefetch FIFO.
// Optional zero-latency bypass of short instructions on an empty queue: define PREFETCH_BYPASS_EN.
module instr_prefetch_queue #(
  parameter int ADDR_W = 20,
  parameter int WORD_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic                    imem_req,
  input  logic [WORD_W-1:0]       imem_data,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WORD_W-1:0]     out_instr,
  output logic                    out_long,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {FETCH_LO, FETCH_HI} state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    pc, pc_nxt;
  logic [WORD_W-1:0]    lo_hold;
  logic [ADDR_W-1:0]    lo_pc;
  logic [2*WORD_W-1:0]  fifo_instr [DEPTH];
  logic                 fifo_long  [DEPTH];
  logic [ADDR_W-1:0]    fifo_pc    [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;

  logic                 full, word_long, fifo_valid;
  logic                 push, pop, lo_load, bypass_hit, bypass_take;
  logic [2*WORD_W-1:0]  push_instr;
  logic                 push_long;
  logic [ADDR_W-1:0]    push_pc;

  assign full       = (level == LVL_W'(DEPTH));
  assign word_long  = imem_data[WORD_W-1];
  assign imem_addr  = pc;
  // The reset term keeps the memory port idle while reset is held.
  assign imem_req   = reset && !redirect && !full;
  assign fifo_valid = (level != '0) && !redirect;
  assign pop        = fifo_valid && out_ready;

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit = reset && !redirect && (level == '0) && (state == FETCH_LO) && !word_long;
`else
  assign bypass_hit = 1'b0;
`endif
  assign bypass_take = bypass_hit && out_ready;
  assign out_valid   = fifo_valid || bypass_hit;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    push       = 1'b0;
    lo_load    = 1'b0;
    push_instr = {{WORD_W{1'b0}}, imem_data};
    push_long  = 1'b0;
    push_pc    = pc;
    if (imem_req) begin
      pc_nxt = pc + ADDR_W'(1);
      if (state == FETCH_LO) begin
        if (word_long) begin
          lo_load   = 1'b1;
          state_nxt = FETCH_HI;
        end else begin
          push = !bypass_take;
        end
      end else begin
        push       = 1'b1;
        push_instr = {imem_data, lo_hold};
        push_long  = 1'b1;
        push_pc    = lo_pc;
        state_nxt  = FETCH_LO;
      end
    end
  end

  always_comb begin
    out_instr = '0;
    out_long  = 1'b0;
    out_pc    = '0;
    if (bypass_hit) begin
      out_instr = {{WORD_W{1'b0}}, imem_data};
      out_pc    = pc;
    end else if (level != '0) begin
      out_instr = fifo_instr[rd_ptr];
      out_long  = fifo_long[rd_ptr];
      out_pc    = fifo_pc[rd_ptr];
    end
  end

  // Control state: redirect discards everything buffered, including a held first half.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= FETCH_LO;
      pc     <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (redirect) begin
      state  <= FETCH_LO;
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Datapath storage is qualified by level/state, so it needs no reset.
  always_ff @(posedge clock) begin
    if (lo_load) begin
      lo_hold <= imem_data;
      lo_pc   <= pc;
    end
    if (push) begin
      fifo_instr[wr_ptr] <= push_instr;
      fifo_long[wr_ptr]  <= push_long;
      fifo_pc[wr_ptr]    <= push_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a scoreboard of expected decoder-side instructions.
module tb_instr_prefetch_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_data;
  logic        redirect;
  logic [19:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_long;
  logic [19:0] out_pc;
  logic [2:0]  level;

  typedef struct packed {
    logic [31:0] instr;
    logic        lng;
    logic [19:0] pc;
  } entry_t;

  entry_t      sb[$];
  logic [15:0] mem [int unsigned];
  int          mem_ver = 0;
  int          total = 0;
  int          bad = 0;

  instr_prefetch_queue #(.ADDR_W(20), .WORD_W(16), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_long(out_long), .out_pc(out_pc), .level(level)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_rd(input logic [19:0] a, input int v);
    if (v < 0) return 16'h0;
    return mem.exists(32'(a)) ? mem[32'(a)] : 16'h0;
  endfunction

  assign imem_data = mem_rd(imem_addr, mem_ver);

  function automatic entry_t mk(input logic [31:0] i, input logic l, input logic [19:0] p);
    return {i, l, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    entry_t e;
    @(negedge clock);
    if (out_valid && out_ready) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_instr", 64'(out_instr), 64'(e.instr));
        chk("sb_long", 64'(out_long), 64'(e.lng));
        chk("sb_pc", 64'(out_pc), 64'(e.pc));
      end
    end
  endtask

  task automatic ed();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc();
    nx();
    ed();
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    mem[0] = 16'h0007;
`else
    mem[0] = 16'h0001;
`endif
    mem[1] = 16'h0002; mem[2] = 16'h0003;
    mem[4] = 16'h8010; mem[5] = 16'h1234;
    mem[32'h10] = 16'h0011; mem[32'h11] = 16'h0012; mem[32'h12] = 16'h8020;
    mem[32'h100] = 16'h0042; mem[32'hFFFFF] = 16'h8001;
    mem_ver++;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_long", 64'(out_long), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    reset = 1'b1; out_ready = 1'b1;

`ifdef PREFETCH_BYPASS_EN
    // Empty queue, short word, decoder ready: presented in the same cycle.
    sb.push_back(mk(32'h7, 1'b0, 20'h0));
    nx();
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_instr", 64'(out_instr), 64'h7);
    chk("byp_level", 64'(level), 64'd0);
    ed();
    sb.push_back(mk(32'h2, 1'b0, 20'h1));
    nx();
    chk("byp_level2", 64'(level), 64'd0);
    chk("byp_addr", 64'(imem_addr), 64'd1);
    ed();
    redirect = 1'b1; redirect_pc = 20'h10; out_ready = 1'b0;
    cyc();
    redirect = 1'b0;
`else
    // Three short words streamed with the decoder always ready.
    sb.push_back(mk(32'h1, 1'b0, 20'h0));
    nx(); chk("c0_valid", 64'(out_valid), 64'd0); ed();
    sb.push_back(mk(32'h2, 1'b0, 20'h1));
    nx(); chk("c1_valid", 64'(out_valid), 64'd1); ed();
    sb.push_back(mk(32'h3, 1'b0, 20'h2));
    cyc();
    cyc();
    // Long instruction at 4.
    redirect = 1'b1; redirect_pc = 20'h4; sb.delete();
    nx(); chk("redir_valid", 64'(out_valid), 64'd0); ed();
    redirect = 1'b0;
    nx(); chk("long_lvl0", 64'(level), 64'd0); ed();
    sb.push_back(mk(32'h12348010, 1'b1, 20'h4));
    nx(); chk("long_wait", 64'(out_valid), 64'd0); ed();
    nx(); chk("long_valid", 64'(out_valid), 64'd1); ed();
    // Fill the FIFO with the decoder stalled.
    redirect = 1'b1; redirect_pc = 20'h0; out_ready = 1'b0; sb.delete();
    cyc();
    redirect = 1'b0;
    sb.push_back(mk(32'h1, 1'b0, 20'h0)); cyc();
    sb.push_back(mk(32'h2, 1'b0, 20'h1)); cyc();
    sb.push_back(mk(32'h3, 1'b0, 20'h2)); cyc();
    sb.push_back(mk(32'h0, 1'b0, 20'h3)); cyc();
    out_ready = 1'b1;
    nx();
    chk("full_level", 64'(level), 64'd4);
    chk("full_req", 64'(imem_req), 64'd0);
    chk("full_addr", 64'(imem_addr), 64'd4);
    ed();
    out_ready = 1'b0;
    nx();
    chk("resume_level", 64'(level), 64'd3);
    chk("resume_req", 64'(imem_req), 64'd1);
    chk("resume_addr", 64'(imem_addr), 64'd4);
    ed();
    sb.push_back(mk(32'h12348010, 1'b1, 20'h4));
    nx(); chk("resume_hi_req", 64'(imem_req), 64'd1); ed();
    // Redirect between halves of a long instruction with two entries queued.
    redirect = 1'b1; redirect_pc = 20'h10; sb.delete();
    nx(); chk("refill_level", 64'(level), 64'd4); ed();
    redirect = 1'b0;
    sb.push_back(mk(32'h11, 1'b0, 20'h10)); cyc();
    sb.push_back(mk(32'h12, 1'b0, 20'h11)); cyc();
    cyc();
    redirect = 1'b1; redirect_pc = 20'h100; sb.delete();
    nx();
    chk("mid_level", 64'(level), 64'd2);
    chk("mid_valid", 64'(out_valid), 64'd0);
    ed();
    redirect = 1'b0;
    sb.push_back(mk(32'h42, 1'b0, 20'h100));
    nx(); chk("flush_level", 64'(level), 64'd0); ed();
    out_ready = 1'b1;
    nx(); chk("flush_valid", 64'(out_valid), 64'd1); ed();
    // Long instruction straddling the address wrap.
    redirect = 1'b1; redirect_pc = 20'hFFFFF; out_ready = 1'b0; sb.delete();
    mem[0] = 16'h0055; mem_ver++;
    cyc();
    redirect = 1'b0;
    nx(); chk("wrap_addr_lo", 64'(imem_addr), 64'hFFFFF); ed();
    sb.push_back(mk(32'h00558001, 1'b1, 20'hFFFFF));
    nx(); chk("wrap_addr_hi", 64'(imem_addr), 64'd0); ed();
    out_ready = 1'b1;
    nx();
    chk("wrap_next", 64'(imem_addr), 64'd1);
    chk("wrap_valid", 64'(out_valid), 64'd1);
    ed();
    out_ready = 1'b0;
`endif
    // Asynchronous reset mid-cycle.
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_req", 64'(imem_req), 64'd0);
    chk("arst_addr", 64'(imem_addr), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
